// File: rtl/wb_slave_sram_pkg.sv
// Shared encodings and helpers for the Wishbone SRAM slave.
package wb_slave_sram_pkg;

  localparam int unsigned ADR_W  = 32;
  localparam int unsigned DAT_W  = 32;
  localparam int unsigned SEL_W  = DAT_W / 8;
  localparam int unsigned WADR_W = ADR_W - 2;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_CONST   = 3'b001,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } ctiCode_t;

  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00,
    BTE_WRAP4  = 2'b01,
    BTE_WRAP8  = 2'b10,
    BTE_WRAP16 = 2'b11
  } bteCode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } burstState_t;

  // One response slot; an empty slot has both ack and err low.
  typedef struct packed {
    logic             ack;
    logic             err;
    logic [DAT_W-1:0] dat;
  } respBeat_t;

  // Word-address bits that take part in the increment for a burst type.
  function automatic logic [WADR_W-1:0] wrapMask(input logic [1:0] bte);
    case (bte)
      BTE_WRAP4:  wrapMask = WADR_W'(3);
      BTE_WRAP8:  wrapMask = WADR_W'(7);
      BTE_WRAP16: wrapMask = WADR_W'(15);
      default:    wrapMask = '1;
    endcase
  endfunction

endpackage

// File: rtl/wb_resp_pipe.sv
// Fixed-depth response delay line with synchronous flush.
module wb_resp_pipe
  import wb_slave_sram_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             inAck,
  input  logic             inErr,
  input  logic [DAT_W-1:0] inDat,
  output logic             outAck,
  output logic             outErr,
  output logic [DAT_W-1:0] outDat
);

  respBeat_t stage [DEPTH];

  // Advance one slot per cycle; a flush empties every slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
    end else begin
      stage[0] <= '{ack: inAck, err: inErr, dat: inDat};
      for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
    end
  end

  assign outAck = stage[DEPTH-1].ack;
  assign outErr = stage[DEPTH-1].err;
  assign outDat = stage[DEPTH-1].dat;

endmodule

// File: rtl/wb_slave_sram.sv
// Pipelined Wishbone B4 slave over an on-chip SRAM, with burst checking
// and optional periodic stall injection.
module wb_slave_sram
  import wb_slave_sram_pkg::*;
#(
  parameter logic [ADR_W-1:0] WBA          = 32'h0000_0000,
  parameter int unsigned      WS_P2        = 12,
  parameter int unsigned      RD_LATENCY   = 2,
  parameter int unsigned      STALL_PERIOD = 0
) (
  input  logic             CLK,
  input  logic             RST_ASYNC,
  input  logic [ADR_W-1:0] WB_ADR_IN,
  input  logic             WB_CYC_IN,
  input  logic             WB_STB_IN,
  input  logic             WB_WE_IN,
  input  logic [SEL_W-1:0] WB_SEL_IN,
  input  logic [2:0]       WB_CTI_IN,
  input  logic [1:0]       WB_BTE_IN,
  input  logic [DAT_W-1:0] WB_WR_DAT_IN,
  output logic             WB_ACK_OUT,
  output logic             WB_ERR_OUT,
  output logic             WB_STALL_OUT,
  output logic [DAT_W-1:0] WB_RD_DAT_OUT
);

  localparam int unsigned MEM_AW    = WS_P2 - 2;
  localparam int unsigned MEM_DEPTH = 1 << MEM_AW;
  localparam int unsigned CNT_W     = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam int unsigned CNT_MAX   = (STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0;

  logic [DAT_W-1:0]  mem [MEM_DEPTH];
  burstState_t       state, nextState;
  logic [WADR_W-1:0] expAddr, nextExp, wordAddr, incrAddr, mask;
  logic [MEM_AW-1:0] memIdx;
  logic [CNT_W-1:0]  beatCnt;
  logic              stallQ, accept, inRange, burstErr, beatErr, doWrite;
  logic [DAT_W-1:0]  rdDat;
  logic [1:0]        unusedAdrLsb;

  assign unusedAdrLsb = WB_ADR_IN[1:0];
  assign wordAddr     = WB_ADR_IN[ADR_W-1:2];
  assign memIdx       = WB_ADR_IN[WS_P2-1:2];
  assign inRange      = (WB_ADR_IN >> WS_P2) == (WBA >> WS_P2);
  assign accept       = WB_CYC_IN & WB_STB_IN & ~stallQ;
  assign beatErr      = ~inRange | burstErr;
  assign doWrite      = accept & WB_WE_IN & ~beatErr;
  assign rdDat        = (accept & ~WB_WE_IN & ~beatErr) ? mem[memIdx] : '0;
  assign WB_STALL_OUT = stallQ;

  // Byte-lane writes commit at the accept edge; the array is never reset.
  always_ff @(posedge CLK) begin
    if (doWrite) begin
      for (int b = 0; b < int'(SEL_W); b++) begin
        if (WB_SEL_IN[b]) mem[memIdx][8*b +: 8] <= WB_WR_DAT_IN[8*b +: 8];
      end
    end
  end

  // Burst checker state and expected next word address.
  always_ff @(posedge CLK or posedge RST_ASYNC) begin
    if (RST_ASYNC) begin
      state   <= IDLE;
      expAddr <= '0;
    end else begin
      state   <= nextState;
      expAddr <= nextExp;
    end
  end

  // Burst checker next state; any mismatch re-latches from the beat's address.
  always_comb begin
    nextState = state;
    nextExp   = expAddr;
    burstErr  = 1'b0;
    mask      = wrapMask(WB_BTE_IN);
    incrAddr  = (wordAddr & ~mask) | ((wordAddr + WADR_W'(1)) & mask);
    if (state == BURST && accept && wordAddr != expAddr) burstErr = 1'b1;
    if (!WB_CYC_IN) begin
      nextState = IDLE;
    end else if (accept) begin
      case (WB_CTI_IN)
        CTI_CONST: begin
          nextState = BURST;
          nextExp   = wordAddr;
        end
        CTI_INCR: begin
          nextState = BURST;
          nextExp   = incrAddr;
        end
        default: nextState = IDLE;
      endcase
    end
  end

  // Accepted-beat counter; its wrap raises STALL for the following cycle only.
  always_ff @(posedge CLK or posedge RST_ASYNC) begin
    if (RST_ASYNC) begin
      beatCnt <= '0;
      stallQ  <= 1'b0;
    end else begin
      stallQ <= 1'b0;
      if (STALL_PERIOD != 0 && accept) begin
        if (beatCnt == CNT_W'(CNT_MAX)) begin
          beatCnt <= '0;
          stallQ  <= 1'b1;
        end else begin
          beatCnt <= beatCnt + CNT_W'(1);
        end
      end
    end
  end

  wb_resp_pipe #(
    .DEPTH (RD_LATENCY)
  ) respPipe (
    .clk    (CLK),
    .rst    (RST_ASYNC),
    .flush  (~WB_CYC_IN),
    .inAck  (accept & ~beatErr),
    .inErr  (accept & beatErr),
    .inDat  (rdDat),
    .outAck (WB_ACK_OUT),
    .outErr (WB_ERR_OUT),
    .outDat (WB_RD_DAT_OUT)
  );

endmodule

// File: tb/tb_wb_slave_sram.sv
// Directed bench for wb_slave_sram: dut0 is the default build (latency 2,
// no stalls); dut1 uses latency 4 with a stall after every 3 beats.
module tb_wb_slave_sram;

  logic        clk, rst, cyc, stb, we;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack0, err0, stall0, ack1, err1, stall1;
  logic [31:0] rdat0, rdat1;

  int assertCnt = 0;
  int failCnt   = 0;

  // Beat table for a back-to-back sequence and its expected responses.
  logic [31:0] sAdr [8];
  logic [31:0] sDat [8];
  logic [31:0] sExp [8];
  logic        sWe  [8];
  logic [3:0]  sSel [8];
  logic [2:0]  sCti [8];
  logic [1:0]  sBte [8];
  logic        sAck [8];
  logic        sErr [8];

  wb_slave_sram #(.WBA(32'h0), .WS_P2(12), .RD_LATENCY(2), .STALL_PERIOD(0)) dut0 (
    .CLK(clk), .RST_ASYNC(rst), .WB_ADR_IN(adr), .WB_CYC_IN(cyc), .WB_STB_IN(stb),
    .WB_WE_IN(we), .WB_SEL_IN(sel), .WB_CTI_IN(cti), .WB_BTE_IN(bte),
    .WB_WR_DAT_IN(wdat), .WB_ACK_OUT(ack0), .WB_ERR_OUT(err0),
    .WB_STALL_OUT(stall0), .WB_RD_DAT_OUT(rdat0));

  wb_slave_sram #(.WBA(32'h0), .WS_P2(12), .RD_LATENCY(4), .STALL_PERIOD(3)) dut1 (
    .CLK(clk), .RST_ASYNC(rst), .WB_ADR_IN(adr), .WB_CYC_IN(cyc), .WB_STB_IN(stb),
    .WB_WE_IN(we), .WB_SEL_IN(sel), .WB_CTI_IN(cti), .WB_BTE_IN(bte),
    .WB_WR_DAT_IN(wdat), .WB_ACK_OUT(ack1), .WB_ERR_OUT(err1),
    .WB_STALL_OUT(stall1), .WB_RD_DAT_OUT(rdat1));

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCnt++;
    if (obs !== exp) begin
      failCnt++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setBeat(input int i, input logic [31:0] a, input logic w, input logic [3:0] s,
                         input logic [31:0] d, input logic [2:0] c, input logic [1:0] b,
                         input logic eAck, input logic eErr, input logic [31:0] eDat);
    sAdr[i] = a; sWe[i] = w; sSel[i] = s; sDat[i] = d; sCti[i] = c; sBte[i] = b;
    sAck[i] = eAck; sErr[i] = eErr; sExp[i] = eDat;
  endtask

  // Issue n beats back-to-back on dut0 and check each response one cycle later.
  task automatic runSeq(input int n, input string tag);
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        cyc = 1'b1; stb = 1'b1; adr = sAdr[i]; we = sWe[i]; sel = sSel[i];
        wdat = sDat[i]; cti = sCti[i]; bte = sBte[i];
      end else begin
        stb = 1'b0;
      end
      tick();
      if (i == 0) begin
        checkEq($sformatf("%s early ack", tag), 32'(ack0), 32'd0);
      end else begin
        checkEq($sformatf("%s b%0d ack", tag, i-1), 32'(ack0), 32'(sAck[i-1]));
        checkEq($sformatf("%s b%0d err", tag, i-1), 32'(err0), 32'(sErr[i-1]));
        checkEq($sformatf("%s b%0d dat", tag, i-1), rdat0, sExp[i-1]);
      end
    end
    tick();
    checkEq($sformatf("%s tail ack", tag), 32'(ack0), 32'd0);
    checkEq($sformatf("%s tail err", tag), 32'(err0), 32'd0);
    checkEq($sformatf("%s tail dat", tag), rdat0, 32'd0);
    cyc = 1'b0; cti = 3'b000; bte = 2'b00;
    tick();
  endtask

  task automatic resetPulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    clk = 1'b0; rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; wdat = '0; sel = '0; cti = '0; bte = '0;
    #1 rst = 1'b1;
    #1;
    checkEq("rst ack0", 32'(ack0), 32'd0);
    checkEq("rst err0", 32'(err0), 32'd0);
    checkEq("rst stall0", 32'(stall0), 32'd0);
    checkEq("rst dat0", rdat0, 32'd0);
    checkEq("rst stall1", 32'(stall1), 32'd0);
    checkEq("rst ack1", 32'(ack1), 32'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    tick();

    // Single write then read
    setBeat(0, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 3'b000, 2'b00, 1'b1, 1'b0, 32'h0);
    runSeq(1, "wr10");
    setBeat(0, 32'h10, 1'b0, 4'hF, 32'h0, 3'b000, 2'b00, 1'b1, 1'b0, 32'hDEADBEEF);
    runSeq(1, "rd10");

    // Byte lanes, with the read immediately after the writes
    setBeat(0, 32'h20, 1'b1, 4'hF, 32'h11223344, 3'b000, 2'b00, 1'b1, 1'b0, 32'h0);
    setBeat(1, 32'h20, 1'b1, 4'h5, 32'hAABBCCDD, 3'b000, 2'b00, 1'b1, 1'b0, 32'h0);
    setBeat(2, 32'h20, 1'b0, 4'hF, 32'h0,        3'b000, 2'b00, 1'b1, 1'b0, 32'h11BB33DD);
    runSeq(3, "lanes");

    // Out of range: read errs, write errs and does not alias onto 0x10
    setBeat(0, 32'h1000, 1'b0, 4'hF, 32'h0,        3'b000, 2'b00, 1'b0, 1'b1, 32'h0);
    setBeat(1, 32'h1010, 1'b1, 4'hF, 32'h0BADF00D, 3'b000, 2'b00, 1'b0, 1'b1, 32'h0);
    setBeat(2, 32'h10,   1'b0, 4'hF, 32'h0,        3'b000, 2'b00, 1'b1, 1'b0, 32'hDEADBEEF);
    runSeq(3, "oor");

    // Wrap4 burst writes, then read back
    setBeat(0, 32'h40, 1'b1, 4'hF, 32'h55AA55AA, 3'b000, 2'b00, 1'b1, 1'b0, 32'h0);
    runSeq(1, "mark");
    setBeat(0, 32'h38, 1'b1, 4'hF, 32'hB0000000, 3'b010, 2'b01, 1'b1, 1'b0, 32'h0);
    setBeat(1, 32'h3C, 1'b1, 4'hF, 32'hB0000001, 3'b010, 2'b01, 1'b1, 1'b0, 32'h0);
    setBeat(2, 32'h30, 1'b1, 4'hF, 32'hB0000002, 3'b010, 2'b01, 1'b1, 1'b0, 32'h0);
    setBeat(3, 32'h34, 1'b1, 4'hF, 32'hB0000003, 3'b111, 2'b01, 1'b1, 1'b0, 32'h0);
    runSeq(4, "wrap4");
    setBeat(0, 32'h30, 1'b0, 4'hF, 32'h0, 3'b000, 2'b00, 1'b1, 1'b0, 32'hB0000002);
    setBeat(1, 32'h34, 1'b0, 4'hF, 32'h0, 3'b000, 2'b00, 1'b1, 1'b0, 32'hB0000003);
    setBeat(2, 32'h38, 1'b0, 4'hF, 32'h0, 3'b000, 2'b00, 1'b1, 1'b0, 32'hB0000000);
    setBeat(3, 32'h3C, 1'b0, 4'hF, 32'h0, 3'b000, 2'b00, 1'b1, 1'b0, 32'hB0000001);
    runSeq(4, "wrap4rd");

    // Broken wrap4: 0x40 where 0x30 is due errs; checker re-latches so 0x44 follows cleanly
    setBeat(0, 32'h38, 1'b1, 4'hF, 32'hE0000000, 3'b010, 2'b01, 1'b1, 1'b0, 32'h0);
    setBeat(1, 32'h3C, 1'b1, 4'hF, 32'hE0000001, 3'b010, 2'b01, 1'b1, 1'b0, 32'h0);
    setBeat(2, 32'h40, 1'b1, 4'hF, 32'hE0000002, 3'b010, 2'b01, 1'b0, 1'b1, 32'h0);
    setBeat(3, 32'h44, 1'b1, 4'hF, 32'hE0000003, 3'b111, 2'b01, 1'b1, 1'b0, 32'h0);
    runSeq(4, "wrap4bad");
    setBeat(0, 32'h40, 1'b0, 4'hF, 32'h0, 3'b000, 2'b00, 1'b1, 1'b0, 32'h55AA55AA);
    setBeat(1, 32'h44, 1'b0, 4'hF, 32'h0, 3'b000, 2'b00, 1'b1, 1'b0, 32'hE0000003);
    setBeat(2, 32'h38, 1'b0, 4'hF, 32'h0, 3'b000, 2'b00, 1'b1, 1'b0, 32'hE0000000);
    runSeq(3, "badrd");

    // Stall injection on dut1: STALL after edges 2,6,10; acks trail accepts by 4
    resetPulse();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h100; sel = 4'hF; cti = 3'b000;
    wdat = 32'h12345678;
    checkEq("stall pre", 32'(stall1), 32'd0);
    for (int k = 0; k < 12; k++) begin
      tick();
      checkEq($sformatf("stall k%0d", k), 32'(stall1), 32'((k % 4) == 2));
      checkEq($sformatf("stall ack k%0d", k), 32'(ack1), 32'((k >= 3) && ((k % 4) != 2)));
      checkEq($sformatf("nostall k%0d", k), 32'(stall0), 32'd0);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();

    // Abort: CYC and STB fall together with beats in flight
    resetPulse();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h10;
    tick();
    adr = 32'h14;
    tick();
    checkEq("abort first ack0", 32'(ack0), 32'd1);
    checkEq("abort early ack1", 32'(ack1), 32'd0);
    cyc = 1'b0; stb = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      checkEq($sformatf("abort ack0 k%0d", k), 32'(ack0), 32'd0);
      checkEq($sformatf("abort ack1 k%0d", k), 32'(ack1), 32'd0);
      checkEq($sformatf("abort err1 k%0d", k), 32'(err1), 32'd0);
    end

    // Reset mid-burst: outputs clear asynchronously; next beat starts from IDLE
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h10; cti = 3'b010; bte = 2'b00;
    tick();
    adr = 32'h14;
    tick();
    checkEq("mid ack pre", 32'(ack0), 32'd1);
    checkEq("mid dat pre", rdat0, 32'hDEADBEEF);
    #2 rst = 1'b1;
    #1;
    checkEq("mid rst ack", 32'(ack0), 32'd0);
    checkEq("mid rst err", 32'(err0), 32'd0);
    checkEq("mid rst stall", 32'(stall0), 32'd0);
    checkEq("mid rst dat", rdat0, 32'd0);
    cyc = 1'b0; stb = 1'b0; cti = 3'b000;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    tick();
    checkEq("post rst ack", 32'(ack0), 32'd0);
    setBeat(0, 32'h200, 1'b1, 4'hF, 32'h0000C0DE, 3'b010, 2'b00, 1'b1, 1'b0, 32'h0);
    setBeat(1, 32'h204, 1'b1, 4'hF, 32'h0000C0DF, 3'b111, 2'b00, 1'b1, 1'b0, 32'h0);
    runSeq(2, "postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
